pipe_ctrl: RTL and testbench

Pipeline control responder for the 5-stage MIPS-style core. It consumes the hazard unit's `Stall`, the EXE stage's `Br_Taken` and the MEM stage's SRAM handshake. From these it drives the freeze, flush and bubble controls for PC, IF/ID and ID/EX. It tracks multi-cycle memory waits with a timeout watchdog and optionally keeps saturating performance counters.

---
 rtl/pipe_ctrl.sv | 126 ++++++++++++
 tb/tb_pipe_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline freeze/flush/bubble controller with memory-wait watchdog (optional counters: PIPE_PERF_CNT_EN)
module pipe_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Stall,
    input  logic             Br_Taken,
    input  logic             Mem_R_En,
    input  logic             Mem_W_En,
    input  logic             Mem_Ready,
    output logic             Global_Freeze,
    output logic             PC_Freeze,
    output logic             IF_ID_Freeze,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic             Mem_Timeout,
    output logic [CNT_W-1:0] Stall_Cnt,
    output logic [CNT_W-1:0] Flush_Cnt,
    output logic [CNT_W-1:0] Mem_Wait_Cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        HALT     = 2'b10
    } state_t;

    localparam logic [TO_W-1:0] TIMEOUT_V = TO_W'(MEM_TIMEOUT);

    state_t          state;
    state_t          state_nxt;
    logic [TO_W-1:0] wait_cnt;
    logic [TO_W-1:0] wait_cnt_nxt;
    logic            req;
    logic            hazard_bubble;

    assign req = Mem_R_En | Mem_W_En;

    // State and wait counter registers; reset drops straight back to RUN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Next-state: Ready beats abort, abort beats timeout; HALT only leaves via reset
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            RUN: begin
                if (req && !Mem_Ready) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = {{(TO_W-1){1'b0}}, 1'b1};
                end
            end
            MEM_WAIT: begin
                if (Mem_Ready || !req) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == TIMEOUT_V) begin
                    state_nxt = HALT;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = HALT;
        endcase
    end

    // Pipeline controls: a freeze masks everything, then branch flush beats hazard stall
    always_comb begin
        Global_Freeze = 1'b0;
        PC_Freeze     = 1'b0;
        IF_ID_Freeze  = 1'b0;
        IF_ID_Flush   = 1'b0;
        ID_EX_Bubble  = 1'b0;
        hazard_bubble = 1'b0;
        if (state == HALT || (state != HALT && req && !Mem_Ready)) begin
            Global_Freeze = 1'b1;
        end else if (Br_Taken) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
        end else if (Stall) begin
            PC_Freeze     = 1'b1;
            IF_ID_Freeze  = 1'b1;
            ID_EX_Bubble  = 1'b1;
            hazard_bubble = 1'b1;
        end
    end

    assign Mem_Timeout = (state == HALT);

`ifdef PIPE_PERF_CNT_EN
    // Saturating event counters; they stick at all-ones rather than wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Stall_Cnt    <= '0;
            Flush_Cnt    <= '0;
            Mem_Wait_Cnt <= '0;
        end else begin
            if (hazard_bubble && Stall_Cnt != {CNT_W{1'b1}})
                Stall_Cnt <= Stall_Cnt + 1'b1;
            if (IF_ID_Flush && Flush_Cnt != {CNT_W{1'b1}})
                Flush_Cnt <= Flush_Cnt + 1'b1;
            if (Global_Freeze && Mem_Wait_Cnt != {CNT_W{1'b1}})
                Mem_Wait_Cnt <= Mem_Wait_Cnt + 1'b1;
        end
    end
`else
    logic unused_bubble;
    assign unused_bubble = hazard_bubble;
    assign Stall_Cnt     = '0;
    assign Flush_Cnt     = '0;
    assign Mem_Wait_Cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          Stall = 1'b0, Br_Taken = 1'b0, Mem_R_En = 1'b0, Mem_W_En = 1'b0, Mem_Ready = 1'b0;
    logic          Global_Freeze, PC_Freeze, IF_ID_Freeze, IF_ID_Flush, ID_EX_Bubble, Mem_Timeout;
    logic [CW-1:0] Stall_Cnt, Flush_Cnt, Mem_Wait_Cnt;

    pipe_ctrl #(.MEM_TIMEOUT(4), .TO_W(8), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .Stall(Stall), .Br_Taken(Br_Taken),
        .Mem_R_En(Mem_R_En), .Mem_W_En(Mem_W_En), .Mem_Ready(Mem_Ready),
        .Global_Freeze(Global_Freeze), .PC_Freeze(PC_Freeze), .IF_ID_Freeze(IF_ID_Freeze),
        .IF_ID_Flush(IF_ID_Flush), .ID_EX_Bubble(ID_EX_Bubble), .Mem_Timeout(Mem_Timeout),
        .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt), .Mem_Wait_Cnt(Mem_Wait_Cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [5:0]    ctrl;   // {GF, PCF, IFIDF, FLUSH, BUBBLE, TIMEOUT}
        logic [CW-1:0] sc, fc, wc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Monitor: outputs are combinational every cycle, so each pushed entry is checked at the falling edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [5:0] act;
            e   = q.pop_front();
            act = {Global_Freeze, PC_Freeze, IF_ID_Freeze, IF_ID_Flush, ID_EX_Bubble, Mem_Timeout};
            total++;
            if (act !== e.ctrl) begin
                bad++;
                $display("FAIL %s ctrl: got %b want %b", e.name, act, e.ctrl);
            end
            total++;
            if (Stall_Cnt !== e.sc) begin
                bad++;
                $display("FAIL %s Stall_Cnt: got %0d want %0d", e.name, Stall_Cnt, e.sc);
            end
            total++;
            if (Flush_Cnt !== e.fc) begin
                bad++;
                $display("FAIL %s Flush_Cnt: got %0d want %0d", e.name, Flush_Cnt, e.fc);
            end
            total++;
            if (Mem_Wait_Cnt !== e.wc) begin
                bad++;
                $display("FAIL %s Mem_Wait_Cnt: got %0d want %0d", e.name, Mem_Wait_Cnt, e.wc);
            end
        end
    end

    // One cycle of stimulus plus its hand-computed expectation
    task automatic step(input string name, input logic r, input logic st, input logic br,
                        input logic re, input logic we, input logic rdy, input logic [5:0] ctrl,
                        input int sc, input int fc, input int wc);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; Stall = st; Br_Taken = br; Mem_R_En = re; Mem_W_En = we; Mem_Ready = rdy;
        e.name = name;
        e.ctrl = ctrl;
`ifdef PIPE_PERF_CNT_EN
        e.sc = CW'(sc); e.fc = CW'(fc); e.wc = CW'(wc);
`else
        e.sc = '0; e.fc = '0; e.wc = '0;
`endif
        q.push_back(e);
    endtask

    initial begin
        int budget;
        //              name        rst st br re we rdy ctrl       sc fc wc
        step("reset",       0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
        // hazard stall for three cycles
        step("stall0",      1, 1, 0, 0, 0, 0, 6'b011010, 0, 0, 0);
        step("stall1",      1, 1, 0, 0, 0, 0, 6'b011010, 1, 0, 0);
        step("stall2",      1, 1, 0, 0, 0, 0, 6'b011010, 2, 0, 0);
        step("stall_end",   1, 0, 0, 0, 0, 0, 6'b000000, 3, 0, 0);
        // branch overrides stall
        step("rst2",        0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
        step("br_stall",    1, 1, 1, 0, 0, 0, 6'b000110, 0, 0, 0);
        step("br_after",    1, 0, 0, 0, 0, 0, 6'b000000, 0, 1, 0);
        // read wait with branch held, Ready in 4th cycle
        step("rst3",        0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
        step("rd_w1",       1, 0, 1, 1, 0, 0, 6'b100000, 0, 0, 0);
        step("rd_w2",       1, 0, 1, 1, 0, 0, 6'b100000, 0, 0, 1);
        step("rd_w3",       1, 0, 1, 1, 0, 0, 6'b100000, 0, 0, 2);
        step("rd_rdy_br",   1, 0, 1, 1, 0, 1, 6'b000110, 0, 0, 3);
        step("rd_after",    1, 0, 0, 0, 0, 0, 6'b000000, 0, 1, 3);
        // write timeout with MEM_TIMEOUT=4
        step("rst4",        0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
        step("to_c0",       1, 0, 0, 0, 1, 0, 6'b100000, 0, 0, 0);
        step("to_c1",       1, 0, 0, 0, 1, 0, 6'b100000, 0, 0, 1);
        step("to_c2",       1, 0, 0, 0, 1, 0, 6'b100000, 0, 0, 2);
        step("to_c3",       1, 0, 0, 0, 1, 0, 6'b100000, 0, 0, 3);
        step("to_c4",       1, 0, 0, 0, 1, 0, 6'b100000, 0, 0, 4);
        step("to_c5_halt",  1, 0, 0, 0, 1, 0, 6'b100001, 0, 0, 5);
        step("halt_masked", 1, 1, 1, 0, 0, 1, 6'b100001, 0, 0, 6);
        step("async_rst",   0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
        // Ready in cycle 4 just avoids timeout
        step("ok_c0",       1, 0, 0, 1, 0, 0, 6'b100000, 0, 0, 0);
        step("ok_c1",       1, 0, 0, 1, 0, 0, 6'b100000, 0, 0, 1);
        step("ok_c2",       1, 0, 0, 1, 0, 0, 6'b100000, 0, 0, 2);
        step("ok_c3",       1, 0, 0, 1, 0, 0, 6'b100000, 0, 0, 3);
        step("ok_c4_rdy",   1, 0, 0, 1, 0, 1, 6'b000000, 0, 0, 4);
        step("ok_after",    1, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 4);
        step("rdy_no_req",  1, 0, 0, 0, 0, 1, 6'b000000, 0, 0, 4);
        step("one_cyc_acc", 1, 0, 0, 1, 0, 1, 6'b000000, 0, 0, 4);
        // aborted request, then hazard in RUN
        step("rst5",        0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
        step("ab_c0",       1, 0, 0, 1, 0, 0, 6'b100000, 0, 0, 0);
        step("ab_c1",       1, 0, 0, 1, 0, 0, 6'b100000, 0, 0, 1);
        step("ab_drop",     1, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 2);
        step("ab_stall",    1, 1, 0, 0, 0, 0, 6'b011010, 0, 0, 2);
        // saturation of a 4-bit counter over 20 hazard cycles
        step("rst6",        0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            step("sat", 1, 1, 0, 0, 0, 0, 6'b011010, (i > 15) ? 15 : i, 0, 0);
        step("sat_end",     1, 0, 0, 0, 0, 0, 6'b000000, 15, 0, 0);

        budget = 0;
        while (q.size() > 0 && budget < 100) begin
            @(posedge clk);
            budget++;
        end
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
